cpu_run_controller: RTL
=======================

# cpu_run_controller

Parametrised run controller for the multi-cycle 16-bit RISC core. It loads a program into instruction memory over a valid/ready stream and holds the core in reset during the load. It then releases the core and watches instruction fetches until the core parks in a self-loop (halt) or a cycle budget expires (timeout). Cycle and fetch counts are exposed for self-checking benches and board bring-up.

## Interface
Parameters:
- DATA_W, 16, instruction/PC width
- ADDR_W, 8, instruction memory address width; DEPTH = 2**ADDR_W
- CNT_W, 16, width of cycle_count / instr_count
- TIMEOUT, 60, maximum RUN cycles before forced stop (1 ≤ TIMEOUT < 2**CNT_W)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ld_valid  in  1  load word valid
- ld_ready  out  1  controller accepts load word
- ld_data  in  DATA_W  program word
- ld_last  in  1  marks final program word
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  instruction memory write address
- imem_wdata  out  DATA_W  instruction memory write data
- cpu_reset  out  1  reset to core, active-high
- instr_fetch  in  1  one-cycle pulse from core when a new instruction is fetched
- pc  in  DATA_W  PC of the instruction being fetched, valid with instr_fetch
- start  in  1  restart request, honoured only in DONE
- done  out  1  run finished
- halted  out  1  run ended by self-loop
- timeout  out  1  run ended by cycle budget
- overflow  out  1  load exceeded DEPTH without ld_last
- cycle_count  out  CNT_W  RUN cycles elapsed
- instr_count  out  CNT_W  fetches observed in RUN

## Operation
- States: LOAD, RUN, DONE. Reset → LOAD.
- LOAD:
  - ld_ready=1, cpu_reset=1.
  - imem_we = ld_valid (combinational); imem_addr = write pointer; imem_wdata = ld_data.
  - On each handshake the pointer increments.
  - Handshake with ld_last → RUN.
  - Handshake at pointer DEPTH-1 without ld_last → RUN with overflow=1; ld_ready is low from the next cycle.
  - The pointer never wraps.
- RUN:
  - cpu_reset=0, ld_ready=0, imem_we=0.
  - cycle_count increments every cycle.
  - instr_count increments on every instr_fetch, including the repeated halt fetch.
  - A last_pc register and its valid bit capture pc on every fetch.
  - Halt: instr_fetch && last_pc_valid && pc==last_pc → DONE, halted=1.
  - Timeout: cycle_count==TIMEOUT-1 with no halt that cycle → DONE, timeout=1.
  - Halt and timeout in the same cycle: halt wins; halted=1, timeout=0. halted and timeout are never both 1.
- DONE:
  - done=1, cpu_reset=1, counters and flags frozen.
  - start → LOAD. Pointer, counters, last_pc_valid, halted, timeout, done and overflow all clear on that edge.
- start outside DONE is ignored. ld_valid outside LOAD is ignored, with no memory write.
- Counters are unsigned CNT_W and cannot wrap, because TIMEOUT bounds them.

## Timing
- Reset values:
  - state=LOAD, pointer=0
  - cpu_reset=1, ld_ready=1
  - done=halted=timeout=overflow=0
  - cycle_count=instr_count=0, last_pc_valid=0
- imem_we / imem_addr / imem_wdata are combinational from the registered pointer and the inputs; the write happens on the same edge as the handshake.
- cpu_reset goes low in the first cycle after the ld_last handshake edge. It goes high in the first cycle after the halt/timeout edge.
- Counters update on the same edge that detects halt/timeout; that RUN cycle is counted.
- The timeout run length is exactly TIMEOUT RUN cycles, leaving cycle_count=TIMEOUT.
- Asserting reset at any time (mid-LOAD, mid-RUN, DONE) returns immediately to reset values. Any partial load must be reloaded.

## Test plan
- Load 02a0, 0848, 0df8, 0ff8 (ld_last on the 4th, ld_valid continuous) → imem writes addr 0..3 on 4 consecutive edges; cpu_reset low the next cycle; ld_ready low.
- RUN with fetches at pc 0, 1, 2, 2 on cycles 2, 5, 8, 11 → halted=1, done=1, timeout=0, instr_count=4, cycle_count=12, cpu_reset high the next cycle.
- RUN with no fetches, TIMEOUT=60 → timeout=1 after exactly 60 RUN cycles, cycle_count=60, instr_count=0. Repeat with the halt fetch on cycle 59 → halted=1, timeout=0.
- ADDR_W=2, stream 5 words with no ld_last → addr 0..3 written; 5th word not accepted (ld_ready=0); overflow=1; RUN entered.
- Assert reset mid-RUN (cycle 7) → cpu_reset=1 and all outputs at reset values asynchronously; reload succeeds from addr 0.
- In DONE, ld_valid with no start → no write. Pulse start → LOAD, counters/flags 0, next load writes addr 0.

Source files
------------

// File: rtl/cpu_run_controller_if.sv
// Load stream, instruction memory write port and core-side signals of the run controller.
// The controller connects to the slave modport; the loader/core side uses master.
interface cpu_run_controller_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              instr_fetch;
    logic [DATA_W-1:0] pc;

    modport master (
        output ld_valid, ld_data, ld_last, instr_fetch, pc,
        input  ld_ready, imem_we, imem_addr, imem_wdata, cpu_reset
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, instr_fetch, pc,
        output ld_ready, imem_we, imem_addr, imem_wdata, cpu_reset
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run controller for the 16-bit RISC core: loads a program, releases the core,
// then stops it on a self-loop (halt) or when the cycle budget runs out.
module cpu_run_controller #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_run_controller_if.slave  bus,
    input  logic                 start,
    output logic                 done,
    output logic                 halted,
    output logic                 timeout,
    output logic                 overflow,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     instr_count
);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [CNT_W-1:0]  cycle_next, instr_next;
    logic [DATA_W-1:0] last_pc, last_pc_next;
    logic              last_pc_valid, last_pc_valid_next;
    logic              halted_next, timeout_next, overflow_next;
    logic              handshake;
    logic              pc_repeat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LOAD;
            ptr           <= '0;
            cycle_count   <= '0;
            instr_count   <= '0;
            last_pc       <= '0;
            last_pc_valid <= 1'b0;
            halted        <= 1'b0;
            timeout       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_next;
            ptr           <= ptr_next;
            cycle_count   <= cycle_next;
            instr_count   <= instr_next;
            last_pc       <= last_pc_next;
            last_pc_valid <= last_pc_valid_next;
            halted        <= halted_next;
            timeout       <= timeout_next;
            overflow      <= overflow_next;
        end
    end

    always_comb begin
        state_next         = state;
        ptr_next           = ptr;
        cycle_next         = cycle_count;
        instr_next         = instr_count;
        last_pc_next       = last_pc;
        last_pc_valid_next = last_pc_valid;
        halted_next        = halted;
        timeout_next       = timeout;
        overflow_next      = overflow;
        handshake          = 1'b0;
        pc_repeat          = 1'b0;
        bus.ld_ready       = 1'b0;
        bus.cpu_reset      = 1'b1;
        bus.imem_we        = 1'b0;
        bus.imem_addr      = ptr;
        bus.imem_wdata     = bus.ld_data;
        done               = 1'b0;

        case (state)
            LOAD: begin
                bus.ld_ready = 1'b1;
                bus.imem_we  = bus.ld_valid;
                handshake    = bus.ld_valid;
                // The pointer saturates at the top address so a runaway stream never wraps onto word 0.
                if (handshake) begin
                    if (ptr != '1) begin
                        ptr_next = ptr + 1'b1;
                    end
                    if (bus.ld_last) begin
                        state_next = RUN;
                    end else if (ptr == '1) begin
                        state_next    = RUN;
                        overflow_next = 1'b1;
                    end
                end
            end
            RUN: begin
                bus.cpu_reset = 1'b0;
                cycle_next    = cycle_count + 1'b1;
                if (bus.instr_fetch) begin
                    instr_next         = instr_count + 1'b1;
                    last_pc_next       = bus.pc;
                    last_pc_valid_next = 1'b1;
                    pc_repeat          = last_pc_valid && (bus.pc == last_pc);
                end
                // A self-loop takes priority over the budget expiring in the same cycle.
                if (pc_repeat) begin
                    state_next  = DONE;
                    halted_next = 1'b1;
                end else if (cycle_count == LAST_CYCLE) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next         = LOAD;
                    ptr_next           = '0;
                    cycle_next         = '0;
                    instr_next         = '0;
                    last_pc_valid_next = 1'b0;
                    halted_next        = 1'b0;
                    timeout_next       = 1'b0;
                    overflow_next      = 1'b0;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end
endmodule
